// File: rtl/nbody_pair_scheduler.sv
// Pair scheduler for the n-body force pipeline: walks (i,j) pairs per timestep, tracks
// in-flight results, then runs the per-body update pass. NBODY_SCHED_SKIP_SELF_EN drops j==i pairs.
module nbody_pair_scheduler #(
  parameter int BODY_ADDR_WIDTH = 9,
  parameter int PIPE_LATENCY    = 122,
  parameter int GAP_WIDTH       = 8,
  parameter int STEP_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [BODY_ADDR_WIDTH:0]   n_bodies,
  input  logic [GAP_WIDTH-1:0]       gap,
  input  logic [STEP_WIDTH-1:0]      n_steps,
  output logic                       issue_valid,
  output logic [BODY_ADDR_WIDTH-1:0] issue_i,
  output logic [BODY_ADDR_WIDTH-1:0] issue_j,
  output logic                       issue_last,
  input  logic                       result_valid,
  output logic                       acc_clear,
  output logic                       update_valid,
  output logic [BODY_ADDR_WIDTH-1:0] update_idx,
  output logic                       busy,
  output logic                       done,
  output logic [STEP_WIDTH-1:0]      step_count,
  output logic [2:0]                 dbg_state
);

`ifdef NBODY_SCHED_SKIP_SELF_EN
  localparam bit SKIP_SELF = 1'b1;
`else
  localparam bit SKIP_SELF = 1'b0;
`endif

  localparam int NW = BODY_ADDR_WIDTH + 1;
  localparam int CW = $clog2(PIPE_LATENCY + 1);

  localparam logic [NW-1:0]              N_ONE    = NW'(1);
  localparam logic [NW-1:0]              N_TWO    = NW'(2);
  localparam logic [BODY_ADDR_WIDTH-1:0] B_ONE    = BODY_ADDR_WIDTH'(1);
  localparam logic [BODY_ADDR_WIDTH-1:0] B_TWO    = BODY_ADDR_WIDTH'(2);
  localparam logic [BODY_ADDR_WIDTH-1:0] FIRST_J  = SKIP_SELF ? B_ONE : '0;
  localparam logic [GAP_WIDTH-1:0]       GAP_ONE  = GAP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0]      STEP_ONE = STEP_WIDTH'(1);
  localparam logic [CW-1:0]              C_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ISSUE  = 3'd2,
    S_DRAIN  = 3'd3,
    S_UPDATE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                     state_q, state_d;
  logic [NW-1:0]              n_q, n_d;
  logic [GAP_WIDTH-1:0]       gap_q, gap_d;
  logic [GAP_WIDTH-1:0]       gcnt_q, gcnt_d;
  logic [STEP_WIDTH-1:0]      steps_q, steps_d;
  logic [STEP_WIDTH-1:0]      step_q, step_d;
  logic [BODY_ADDR_WIDTH-1:0] i_q, i_d;
  logic [BODY_ADDR_WIDTH-1:0] j_q, j_d;
  logic [BODY_ADDR_WIDTH-1:0] upd_q, upd_d;
  logic [CW-1:0]              inflight_q, inflight_d;

  logic [NW-1:0]              last_j;
  logic [BODY_ADDR_WIDTH-1:0] j_inc;
  logic                       fire, pair_last, final_pair, dec;

  // issue_valid is a one-cycle strobe with no back-pressure: the force pipeline accepts
  // every issued pair and returns exactly one result_valid per pair, in issue order.
  assign fire       = (state_q == S_ISSUE) && (gcnt_q == '0);
  assign last_j     = (SKIP_SELF && ({1'b0, i_q} == n_q - N_ONE)) ? n_q - N_TWO : n_q - N_ONE;
  assign pair_last  = ({1'b0, j_q} == last_j);
  assign final_pair = pair_last && ({1'b0, i_q} == n_q - N_ONE);
  assign j_inc      = j_q + B_ONE;
  assign dec        = result_valid && (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    if (fire && !dec)      inflight_d = inflight_q + C_ONE;
    else if (!fire && dec) inflight_d = inflight_q - C_ONE;
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    steps_d = steps_q;
    step_d  = step_q;
    i_d     = i_q;
    j_d     = j_q;
    upd_d   = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          n_d     = n_bodies;
          gap_d   = (gap == '0) ? GAP_ONE : gap;
          steps_d = (n_steps == '0) ? STEP_ONE : n_steps;
          step_d  = '0;
          state_d = (n_bodies < N_TWO) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        i_d     = '0;
        j_d     = FIRST_J;
        gcnt_d  = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (fire) begin
          gcnt_d = gap_q - GAP_ONE;
          if (final_pair) begin
            state_d = S_DRAIN;
          end else if (pair_last) begin
            i_d = i_q + B_ONE;
            j_d = '0;
          end else begin
            // Hop over the diagonal when self-pairs are skipped.
            j_d = (SKIP_SELF && (j_inc == i_q)) ? j_q + B_TWO : j_inc;
          end
        end else begin
          gcnt_d = gcnt_q - GAP_ONE;
        end
      end
      S_DRAIN: begin
        if (inflight_d == '0) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if ({1'b0, upd_q} == n_q - N_ONE) begin
          step_d  = step_q + STEP_ONE;
          state_d = (step_q + STEP_ONE == steps_q) ? S_DONE : S_CLEAR;
        end else begin
          upd_d = upd_q + B_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      gap_q      <= '0;
      gcnt_q     <= '0;
      steps_q    <= '0;
      step_q     <= '0;
      i_q        <= '0;
      j_q        <= '0;
      upd_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      gap_q      <= gap_d;
      gcnt_q     <= gcnt_d;
      steps_q    <= steps_d;
      step_q     <= step_d;
      i_q        <= i_d;
      j_q        <= j_d;
      upd_q      <= upd_d;
      inflight_q <= inflight_d;
    end
  end

  assign issue_valid  = fire;
  assign issue_i      = fire ? i_q : '0;
  assign issue_j      = fire ? j_q : '0;
  assign issue_last   = fire && pair_last;
  assign acc_clear    = (state_q == S_CLEAR);
  assign update_valid = (state_q == S_UPDATE);
  assign update_idx   = update_valid ? upd_q : '0;
  assign busy         = (state_q == S_CLEAR) || (state_q == S_ISSUE) ||
                        (state_q == S_DRAIN) || (state_q == S_UPDATE);
  assign done         = (state_q == S_DONE);
  assign step_count   = step_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_nbody_pair_scheduler.sv
// Bench for nbody_pair_scheduler: table of runs with hand-computed timing, a pair/update
// scoreboard, a 122-cycle pipeline model, plus reset and spurious-result sequences.
module tb_nbody_pair_scheduler;
  localparam int BAW = 9;
  localparam int PL  = 122;
  localparam int W   = 2 * BAW + 1;

`ifdef NBODY_SCHED_SKIP_SELF_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           go;
  logic [BAW:0]   n_bodies;
  logic [7:0]     gap;
  logic [15:0]    n_steps;
  logic           issue_valid;
  logic [BAW-1:0] issue_i;
  logic [BAW-1:0] issue_j;
  logic           issue_last;
  logic           result_valid;
  logic           acc_clear;
  logic           update_valid;
  logic [BAW-1:0] update_idx;
  logic           busy;
  logic           done;
  logic [15:0]    step_count;
  logic [2:0]     dbg_state;

  nbody_pair_scheduler dut (
    .clk(clk), .rst(rst), .go(go), .n_bodies(n_bodies), .gap(gap), .n_steps(n_steps),
    .issue_valid(issue_valid), .issue_i(issue_i), .issue_j(issue_j), .issue_last(issue_last),
    .result_valid(result_valid), .acc_clear(acc_clear), .update_valid(update_valid),
    .update_idx(update_idx), .busy(busy), .done(done), .step_count(step_count),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int             n_pass;
  int             n_total;
  logic [W-1:0]   exp_q[$];
  int             upd_exp_q[$];
  logic [PL-1:0]  pipe;

  typedef struct {
    int n; int g; int s;
    int exp_issues; int exp_last; int exp_done;
    int hold_go; int spur_at;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Advance one cycle; the pipeline model returns each issue 122 cycles later.
  task automatic tick();
    logic iv;
    iv = issue_valid;
    @(posedge clk);
    #1;
    pipe = {pipe[PL-2:0], iv};
    result_valid = pipe[PL-1];
  endtask

  task automatic run_case(input int idx, input vec_t v);
    int geff, seff, cyc, issues, pair_errs, gap_errs, upd_errs, garbage, clears, upd_cnt;
    int first_issue, last_issue, prev_issue, done_at, clear_step_errs, hold_errs, want_u;
    logic [W-1:0] got, want, tmp;
    geff = (v.g == 0) ? 1 : v.g;
    seff = (v.s == 0) ? 1 : v.s;
    exp_q.delete();
    upd_exp_q.delete();
    if (v.n >= 2) begin
      for (int s = 0; s < seff; s++) begin
        for (int i = 0; i < v.n; i++) begin
          for (int j = 0; j < v.n; j++)
            if (!(SKIP && i == j)) exp_q.push_back({1'b0, BAW'(i), BAW'(j)});
          tmp = exp_q.pop_back();
          tmp[W-1] = 1'b1;
          exp_q.push_back(tmp);
        end
        for (int u = 0; u < v.n; u++) upd_exp_q.push_back(u);
      end
    end
    issues = 0; pair_errs = 0; gap_errs = 0; upd_errs = 0; garbage = 0; clears = 0;
    upd_cnt = 0; first_issue = -1; last_issue = -1; prev_issue = -1; done_at = -1;
    clear_step_errs = 0; hold_errs = 0;

    n_bodies = (BAW+1)'(v.n); gap = 8'(v.g); n_steps = 16'(v.s); go = 1'b1;
    tick();
    cyc = 1;
    if (v.hold_go <= cyc) go = 1'b0;
    if (v.n >= 2) begin
      check($sformatf("v%0d_clear_at_k1", idx), acc_clear, 1);
      check($sformatf("v%0d_done_drop", idx), done, 0);
      check($sformatf("v%0d_step_reset", idx), step_count, 0);
    end else begin
      check($sformatf("v%0d_short_done_k1", idx), done, 1);
      check($sformatf("v%0d_short_step0", idx), step_count, 0);
    end

    while (done_at < 0 && cyc < 5000) begin
      if (cyc == v.spur_at) result_valid = 1'b1;
      if (!issue_valid && (issue_i != '0 || issue_j != '0 || issue_last)) garbage++;
      if (!update_valid && update_idx != '0) garbage++;
      if (!(busy ^ done)) garbage++;
      if (!busy && (acc_clear || issue_valid || update_valid)) garbage++;
      if (acc_clear) begin
        clears++;
        if (int'(step_count) != clears - 1) clear_step_errs++;
        prev_issue = -1;
      end
      if (issue_valid) begin
        issues++;
        if (first_issue < 0) first_issue = cyc;
        last_issue = cyc;
        if (prev_issue >= 0 && cyc - prev_issue != geff) gap_errs++;
        prev_issue = cyc;
        got = {issue_last, issue_i, issue_j};
        if (exp_q.size() == 0) pair_errs++;
        else begin
          want = exp_q.pop_front();
          if (got != want) begin
            if (pair_errs == 0)
              $display("FAIL v%0d_pair: got last=%0b i=%0d j=%0d, expected last=%0b i=%0d j=%0d",
                       idx, got[W-1], got[2*BAW-1:BAW], got[BAW-1:0],
                       want[W-1], want[2*BAW-1:BAW], want[BAW-1:0]);
            pair_errs++;
          end
        end
      end
      if (update_valid) begin
        upd_cnt++;
        if (upd_exp_q.size() == 0) upd_errs++;
        else begin
          want_u = upd_exp_q.pop_front();
          if (int'(update_idx) != want_u) upd_errs++;
        end
      end
      if (done) done_at = cyc;
      else begin
        tick();
        cyc++;
        if (v.hold_go <= cyc) go = 1'b0;
      end
    end
    go = 1'b0;
    for (int h = 0; h < 4; h++) begin
      tick();
      if (!done || busy || issue_valid || acc_clear || update_valid) hold_errs++;
    end

    check($sformatf("v%0d_done_cycle", idx), done_at, v.exp_done);
    check($sformatf("v%0d_issue_count", idx), issues, v.exp_issues);
    check($sformatf("v%0d_first_issue", idx), first_issue, (v.n >= 2) ? 2 : -1);
    check($sformatf("v%0d_last_issue", idx), last_issue, v.exp_last);
    check($sformatf("v%0d_pair_errs", idx), pair_errs, 0);
    check($sformatf("v%0d_pairs_left", idx), exp_q.size(), 0);
    check($sformatf("v%0d_gap_errs", idx), gap_errs, 0);
    check($sformatf("v%0d_update_count", idx), upd_cnt, (v.n >= 2) ? v.n * seff : 0);
    check($sformatf("v%0d_update_errs", idx), upd_errs, 0);
    check($sformatf("v%0d_clear_pulses", idx), clears, (v.n >= 2) ? seff : 0);
    check($sformatf("v%0d_clear_step_errs", idx), clear_step_errs, 0);
    check($sformatf("v%0d_idle_garbage", idx), garbage, 0);
    check($sformatf("v%0d_final_steps", idx), step_count, (v.n >= 2) ? seff : 0);
    check($sformatf("v%0d_done_hold", idx), hold_errs, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    // n, gap, steps, issues, last issue, done cycle, hold go until, spurious result at
    if (SKIP) begin
      vecs[0] = '{3, 1, 1,   6,    7,  133,  0, -1};
      vecs[1] = '{2, 0, 1,   2,    3,  128,  0, -1};
      vecs[2] = '{3, 1, 2,  12,  139,  265,  0, -1};
      vecs[3] = '{1, 3, 5,   0,   -1,    1,  0, -1};
      vecs[4] = '{4, 3, 0,  12,   35,  162,  0, -1};
      vecs[5] = '{25, 6, 1, 600, 3596, 3744, 0, -1};
      vecs[6] = '{2, 1, 1,   2,    3,  128, 50,  1};
      vecs[7] = '{0, 1, 1,   0,   -1,    1,  0, -1};
    end else begin
      vecs[0] = '{3, 1, 1,   9,   10,  136,  0, -1};
      vecs[1] = '{2, 0, 1,   4,    5,  130,  0, -1};
      vecs[2] = '{3, 1, 2,  18,  145,  271,  0, -1};
      vecs[3] = '{1, 3, 5,   0,   -1,    1,  0, -1};
      vecs[4] = '{4, 3, 0,  16,   47,  174,  0, -1};
      vecs[5] = '{25, 6, 1, 625, 3746, 3894, 0, -1};
      vecs[6] = '{2, 1, 1,   4,    5,  130, 50,  1};
      vecs[7] = '{0, 1, 1,   0,   -1,    1,  0, -1};
    end

    rst = 1'b1; go = 1'b0; n_bodies = '0; gap = '0; n_steps = '0; result_valid = 1'b0;
    pipe = '0;
    repeat (3) tick();
    pipe = '0;
    result_valid = 1'b0;
    check("reset_outputs", {issue_valid, issue_i, issue_j, issue_last, acc_clear, update_valid,
                            update_idx, busy, done, step_count}, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0;
    tick();
    result_valid = 1'b1;
    tick();
    check("idle_after_spurious", {busy, done, issue_valid, acc_clear, update_valid}, 0);

    for (int k = 0; k < 8; k++) run_case(k, vecs[k]);

    n_bodies = 10'd4; gap = 8'd2; n_steps = 16'd1; go = 1'b1;
    tick();
    go = 1'b0;
    repeat (10) tick();
    check("mid_run_in_issue", dbg_state, 2);
    rst = 1'b1;
    tick();
    pipe = '0;
    result_valid = 1'b0;
    check("mid_rst_outputs", {issue_valid, issue_i, issue_j, issue_last, acc_clear, update_valid,
                              update_idx, busy, done, step_count}, 0);
    check("mid_rst_state", dbg_state, 0);
    rst = 1'b0;
    tick();
    check("post_rst_idle", {busy, done, issue_valid}, 0);
    run_case(100, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/nbody_pair_scheduler.md
Name: nbody_pair_scheduler

Overview:
Sequences the pairwise force pipeline of the n-body accelerator. It walks all (i,j) body pairs for each timestep and issues one pair every `gap` cycles. It tracks in-flight pipeline results, then runs a per-body update pass before starting the next step. It sits between the memory-mapped register block (go, N_BODIES, GAP, step count) and the force datapath and accumulator/integrator.

Parameters:
- BODY_ADDR_WIDTH, 9, body index width (max 512 bodies).
- PIPE_LATENCY, 122, force pipeline latency in cycles; sizes the in-flight counter, width clog2(PIPE_LATENCY+1).
- GAP_WIDTH, 8, width of the issue-spacing input.
- STEP_WIDTH, 16, width of the timestep counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- go  in  1  start pulse; ignored unless the state is IDLE or DONE
- n_bodies  in  BODY_ADDR_WIDTH+1  body count N, sampled on accepted go
- gap  in  GAP_WIDTH  cycles between issues, sampled on go; 0 is treated as 1
- n_steps  in  STEP_WIDTH  timesteps per run, sampled on go; 0 is treated as 1
- issue_valid  out  1  pair presented to pipeline this cycle
- issue_i  out  BODY_ADDR_WIDTH  target body
- issue_j  out  BODY_ADDR_WIDTH  source body
- issue_last  out  1  marks the final pair for the current issue_i
- result_valid  in  1  pipeline output strobe; one per issued pair, in order
- acc_clear  out  1  one-cycle pulse that clears all accumulators at step start
- update_valid  out  1  integrate/write back body update_idx
- update_idx  out  BODY_ADDR_WIDTH  body being updated
- busy  out  1  run in progress
- done  out  1  run complete; held until next accepted go
- step_count  out  STEP_WIDTH  completed steps in the current run

Behaviour:
- Reset: state IDLE; in-flight counter 0; every output 0.
- States: IDLE, CLEAR, ISSUE, DRAIN, UPDATE, DONE.
- Accepted go at edge k:
  - If N<2: DONE at k+1, step_count=0.
  - Otherwise: CLEAR (acc_clear=1) in cycle k+1; ISSUE from cycle k+2.
- ISSUE:
  - Order is i outer 0..N-1, j inner 0..N-1.
  - First issue_valid in the first ISSUE cycle, then exactly every gap cycles; issue_valid is low on the cycles in between.
  - issue_i, issue_j and issue_last are valid only while issue_valid is high, and are 0 otherwise.
  - After the last pair is issued, go to DRAIN.
- In-flight counter:
  - +1 on issue, -1 on result_valid; no change when both occur in the same cycle.
  - result_valid at count 0 is ignored; the counter does not underflow.
- DRAIN: first UPDATE cycle is the cycle after the result_valid that takes the count to 0. If the count is already 0, enter UPDATE on the next cycle.
- UPDATE:
  - update_valid=1 with update_idx=0..N-1 on N consecutive cycles.
  - step_count increments on the cycle after the last update.
  - Then, if step_count==n_steps, go to DONE; otherwise go to CLEAR.
- busy=1 in CLEAR, ISSUE, DRAIN and UPDATE. done=1 only in DONE.
- go while busy is ignored. go in DONE restarts the run: done drops and step_count resets to 0 at the next edge.
- rst during a run: immediately back to IDLE with the reset values above. Flushing the pipeline is the caller's responsibility.

Optional Feature:
- Macro NBODY_SCHED_SKIP_SELF_EN.
- Defined: pairs with j==i are never issued, giving N*(N-1) issues per step. issue_last marks the final j≠i for each i (j=N-2 when i=N-1).
- Undefined: all N*N pairs are issued, including j==i; the pipeline must handle zero separation via softening. issue_last is set at j=N-1.

Test Plan:
- SKIP_SELF_EN defined, N=3, gap=1, n_steps=1, go at k:
  - acc_clear at k+1.
  - Issues at k+2..k+7 in order (0,1),(0,2)L,(1,0),(1,2)L,(2,0),(2,1)L, where L marks issue_last=1.
  - Pipeline model with 122-cycle latency: last result at k+129; update_valid idx 0,1,2 at k+130..k+132; done=1 and step_count=1 from k+133.
- N=25, gap=6, skip-self, n_steps=1 -> 600 issues spaced exactly 6 cycles apart; last issue at k+3596; done asserted after the drain and 25 update cycles.
- N=3, n_steps=2 -> second acc_clear pulse follows the first update pass; 12 issues in total; step_count ends at 2.
- gap=0 and N=2 -> behaves as gap=1: issues (0,1),(1,0) on consecutive cycles. N=1 -> done at k+1, no issue_valid at any point.
- go held high through busy, and a spurious result_valid at count 0 -> no restart and no counter underflow. rst asserted mid-ISSUE -> next cycle IDLE with all outputs 0, and a fresh go runs correctly.
- SKIP_SELF_EN undefined, N=3 -> 9 issues including (0,0),(1,1),(2,2); issue_last at j=2.
